// File: rtl/rvtu_done_watchdog.sv
// Completion tracker and run watchdog for N_CH compute channels.
// Optional macro RVTU_WD_TIMESTAMP_EN adds per-channel completion timestamps and the elapsed counter.
module rvtu_done_watchdog #(
    parameter int N_CH = 2,
    parameter int TO_W = 32,
    parameter int TS_W = 32,
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              clr,
    input  logic [TO_W-1:0]   timeout_val,
    input  logic [N_CH-1:0]   ch_en,
    input  logic [N_CH-1:0]   ch_done,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [TS_W-1:0]   rd_ts,
    output logic [N_CH-1:0]   done_mask,
    output logic              all_done,
    output logic              timeout_err,
    output logic              busy,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_DONE    = 2'd2,
        S_TIMEOUT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [N_CH-1:0]   en_q, en_d;
    logic [N_CH-1:0]   mask_q, mask_d;
    logic [TO_W-1:0]   budget_q, budget_d;
    logic [N_CH-1:0]   new_cap;
    logic [N_CH-1:0]   cap;
    logic              start;

    assign new_cap = en_q & ch_done & ~mask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            en_q     <= '0;
            mask_q   <= '0;
            budget_q <= '0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            mask_q   <= mask_d;
            budget_q <= budget_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        mask_d   = mask_q;
        budget_d = budget_q;
        cap      = '0;
        start    = 1'b0;
        if (state_q == S_RUN) begin
            if (clr) begin
                state_d = S_IDLE;
            end else begin
                cap    = new_cap;
                mask_d = mask_q | new_cap;
                if (budget_q != '0)
                    budget_d = budget_q - TO_W'(1);
                // Completion on the same edge as budget expiry resolves to DONE.
                if ((mask_d & en_q) == en_q)
                    state_d = S_DONE;
                else if (budget_q == TO_W'(1))
                    state_d = S_TIMEOUT;
            end
        end else if (clr) begin
            state_d = S_IDLE;
        end else if (arm) begin
            start    = 1'b1;
            en_d     = ch_en;
            budget_d = timeout_val;
            mask_d   = '0;
            state_d  = (ch_en == '0) ? S_DONE : S_RUN;
        end
    end

    assign state       = state_q;
    assign done_mask   = mask_q;
    assign busy        = (state_q == S_RUN);
    assign all_done    = (state_q == S_DONE);
    assign timeout_err = (state_q == S_TIMEOUT);

`ifdef RVTU_WD_TIMESTAMP_EN
    logic [TS_W-1:0] elapsed_q;
    logic [TS_W-1:0] elapsed_inc;
    logic [TS_W-1:0] ts_q [N_CH];

    assign elapsed_inc = (elapsed_q == '1) ? elapsed_q : elapsed_q + TS_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elapsed_q <= '0;
            for (int i = 0; i < N_CH; i++) ts_q[i] <= '0;
        end else if (start) begin
            elapsed_q <= '0;
            for (int i = 0; i < N_CH; i++) ts_q[i] <= '0;
        end else begin
            if (state_q == S_RUN && !clr)
                elapsed_q <= elapsed_inc;
            for (int i = 0; i < N_CH; i++)
                if (cap[i]) ts_q[i] <= elapsed_inc;
        end
    end

    always_comb begin
        rd_ts = '0;
        for (int i = 0; i < N_CH; i++)
            if (rd_sel == SEL_W'(i)) rd_ts = ts_q[i];
    end
`else
    logic unused_ts;
    assign unused_ts = ^{rd_sel, cap, start};
    assign rd_ts     = '0;
`endif

endmodule

// File: tb/tb_rvtu_done_watchdog.sv
// Randomized and directed bench for rvtu_done_watchdog against a run-cycle reference model.
module tb_rvtu_done_watchdog;
    localparam int N_CH = 2;
    localparam int TO_W = 32;
    localparam int TS_W = 32;
`ifdef RVTU_WD_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            arm = 1'b0;
    logic            clr = 1'b0;
    logic [TO_W-1:0] timeout_val = '0;
    logic [N_CH-1:0] ch_en = '0;
    logic [N_CH-1:0] ch_done = '0;
    logic [0:0]      rd_sel = '0;
    logic [TS_W-1:0] rd_ts;
    logic [N_CH-1:0] done_mask;
    logic            all_done, timeout_err, busy;
    logic [1:0]      state;

    rvtu_done_watchdog #(.N_CH(N_CH), .TO_W(TO_W), .TS_W(TS_W)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .clr(clr),
        .timeout_val(timeout_val), .ch_en(ch_en), .ch_done(ch_done),
        .rd_sel(rd_sel), .rd_ts(rd_ts), .done_mask(done_mask),
        .all_done(all_done), .timeout_err(timeout_err), .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: runs counted in RUN-cycle numbers; 0=IDLE 1=RUN 2=DONE 3=TIMEOUT
    int              m_st;
    logic [N_CH-1:0] m_en, m_mask;
    longint          m_n, m_T;
    longint          m_ts [N_CH];

    function automatic void model_reset();
        m_st = 0; m_en = '0; m_mask = '0; m_n = 0; m_T = 0;
        for (int i = 0; i < N_CH; i++) m_ts[i] = 0;
    endfunction

    function automatic void model_edge();
        if (clr) begin
            m_st = 0;
        end else if (arm && m_st != 1) begin
            m_en = ch_en; m_T = longint'(timeout_val); m_mask = '0; m_n = 1;
            for (int i = 0; i < N_CH; i++) m_ts[i] = 0;
            m_st = (ch_en == '0) ? 2 : 1;
        end else if (m_st == 1) begin
            for (int i = 0; i < N_CH; i++)
                if (m_en[i] && ch_done[i] && !m_mask[i]) begin
                    m_mask[i] = 1'b1;
                    m_ts[i] = m_n;
                end
            if ((m_mask & m_en) == m_en) m_st = 2;
            else if (m_T != 0 && m_n == m_T) m_st = 3;
            m_n++;
        end
    endfunction

    task automatic check_all();
        longint exp_ts;
        exp_ts = TS_EN ? m_ts[rd_sel] : 0;
        chk("state", state, m_st);
        chk("busy", busy, m_st == 1);
        chk("all_done", all_done, m_st == 2);
        chk("timeout_err", timeout_err, m_st == 3);
        chk("done_mask", done_mask, m_mask);
        chk("rd_ts", rd_ts, exp_ts);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        rd_sel = 1'($urandom_range(0, 1));
        #1;
        check_all();
    endtask

    task automatic do_arm(input logic [N_CH-1:0] en, input logic [TO_W-1:0] t);
        ch_en = en; timeout_val = t; arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    int lat;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // normal completion
        do_arm(2'b11, 1000);
        for (int c = 1; c <= 20; c++) begin
            ch_done = {c == 17, c == 5};
            tick();
        end
        ch_done = '0;
        rd_sel = 1'b0; #1;
        chk("norm_ts0", rd_ts, TS_EN ? 5 : 0);
        rd_sel = 1'b1; #1;
        chk("norm_ts1", rd_ts, TS_EN ? 17 : 0);
        chk("norm_all_done", all_done, 1);

        // timeout with one channel done
        do_clr();
        do_arm(2'b11, 50);
        lat = 0;
        for (int c = 1; c <= 60; c++) begin
            ch_done = {1'b0, c == 10};
            tick();
            if (timeout_err && lat == 0) lat = c;
        end
        ch_done = '0;
        chk("to_latency", lat, 50);
        chk("to_mask", done_mask, 2'b01);

        // completion on the expiry edge
        do_arm(2'b11, 20);
        for (int c = 1; c <= 22; c++) begin
            ch_done = {c == 20, c == 3};
            tick();
        end
        ch_done = '0;
        chk("tie_done", all_done, 1);
        chk("tie_to", timeout_err, 0);

        // watchdog disabled, long run, then ignored arm
        do_arm(2'b01, 0);
        for (int c = 0; c < 10000; c++) begin
            ch_done = {1'($urandom_range(0, 1)), 1'b0};
            tick();
        end
        ch_done = '0;
        do_arm(2'b10, 3);
        chk("dis_busy", busy, 1);

        // disabled channel masked
        do_clr();
        do_arm(2'b10, 0);
        for (int c = 1; c <= 12; c++) begin
            ch_done = {c == 12, 1'(c)};
            tick();
        end
        ch_done = '0;
        chk("mask_bits", done_mask, 2'b10);

        // empty enable, clr+arm priority
        do_arm(2'b00, 7);
        chk("empty_done", all_done, 1);
        clr = 1'b1; arm = 1'b1; ch_en = 2'b11;
        tick();
        clr = 1'b0; arm = 1'b0;
        chk("clr_prio", state, 0);

        // re-arm from TIMEOUT
        do_arm(2'b11, 5);
        for (int c = 1; c <= 5; c++) begin
            ch_done = {1'b0, c == 2};
            tick();
        end
        ch_done = '0;
        chk("rearm_to", timeout_err, 1);
        do_arm(2'b11, 9);
        chk("rearm_busy", busy, 1);
        chk("rearm_mask", done_mask, 2'b00);

        // reset in mid-run, checked before the next edge
        do_clr();
        do_arm(2'b11, 100);
        for (int c = 1; c <= 39; c++) begin
            ch_done = {1'b0, c == 7};
            tick();
        end
        ch_done = '0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            arm         = ($urandom % 16) == 0;
            clr         = ($urandom % 40) == 0;
            ch_en       = N_CH'($urandom);
            timeout_val = TO_W'($urandom_range(0, 40));
            ch_done     = {($urandom % 5) == 0, ($urandom % 5) == 0};
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
